// File: rtl/iter_mult_pkg.sv
// Package iter_mult_pkg
// Purpose : shared definitions for the iterative recursive approximate multiplier.
//           It holds the digit width, the FSM state type, and the 2x2 and 4x4
//           approximate multiplier functions.
// Contents:
//   DIGIT_W      digit width handled by the shared core (4)
//   state_t      IDLE / CALC / DONE
//   approx_mul2  2x2 -> 3-bit approximate product (3*3 gives 7)
//   approx_mul4  4x4 -> 8-bit recursive sum of four approx_mul2 results
package iter_mult_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Exact except for 3*3. That product needs 4 bits, so it is clipped to 7
    // and the result fits in 3 bits.
    function automatic logic [2:0] approx_mul2(input logic [1:0] x, input logic [1:0] y);
        if (x == 2'd3 && y == 2'd3) begin
            return 3'd7;
        end
        return 3'(x) * 3'(y);
    endfunction

    // Split both nibbles into 2-bit halves and recombine the four half products
    // with shifts 0, 2, 2 and 4. The largest value is 7+28+28+112 = 175.
    function automatic logic [7:0] approx_mul4(input logic [3:0] x, input logic [3:0] y);
        logic [2:0] m_ll;
        logic [2:0] m_hl;
        logic [2:0] m_lh;
        logic [2:0] m_hh;
        m_ll = approx_mul2(x[1:0], y[1:0]);
        m_hl = approx_mul2(x[3:2], y[1:0]);
        m_lh = approx_mul2(x[1:0], y[3:2]);
        m_hh = approx_mul2(x[3:2], y[3:2]);
        return 8'(m_ll) + (8'(m_hl) << 2) + (8'(m_lh) << 2) + (8'(m_hh) << 4);
    endfunction

endpackage

// File: rtl/rec_mult_core4x4.sv
// Module rec_mult_core4x4
// Purpose : combinational 4x4 multiplier core. It returns either the exact
//           product or the recursive approximate product.
// Ports   :
//   a      in  4   multiplicand digit
//   b      in  4   multiplier digit
//   approx in  1   1 = approximate product, 0 = exact product
//   p      out 8   selected product
module rec_mult_core4x4
    import iter_mult_pkg::*;
(
    input  logic [DIGIT_W-1:0]   a,
    input  logic [DIGIT_W-1:0]   b,
    input  logic                 approx,
    output logic [2*DIGIT_W-1:0] p
);

    logic [2*DIGIT_W-1:0] exact_p;

    always_comb begin
        exact_p = (2*DIGIT_W)'(a) * (2*DIGIT_W)'(b);
        p       = approx ? approx_mul4(a, b) : exact_p;
    end

endmodule

// File: rtl/iter_recursive_mult.sv
// Module iter_recursive_mult
// Purpose : iterative approximate multiplier.
//           - WIDTH-bit operands are split into D=WIDTH/4 digits.
//           - One shared 4x4 core is applied to the N=D*D digit pairs, one pair per cycle.
//           - A digit pair (i,j) uses the approximate core when i+j >= approx_thr.
//           - Only one operation is in flight at a time.
//           - out_valid rises N cycles after the accepting edge.
// Build option:
//   APPROX_ERR_STAT_EN  when defined, out_err reports (exact product - y) while
//                       out_valid is high. Otherwise out_err is tied to zero.
// Ports   :
//   clk        in  1              rising-edge clock
//   rst_n      in  1              asynchronous active-low reset
//   in_valid   in  1              operands/threshold valid
//   in_ready   out 1              block can accept an operation
//   a          in  WIDTH          multiplicand (unsigned)
//   b          in  WIDTH          multiplier (unsigned)
//   approx_thr in  clog2(2*D)     approximation threshold on digit significance
//   out_valid  out 1              result valid
//   out_ready  in  1              consumer accepts result
//   y          out 2*WIDTH        product
//   out_err    out 2*WIDTH        exact minus y (error-statistics build only)
module iter_recursive_mult
    import iter_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [$clog2(WIDTH/2)-1:0]   approx_thr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH-1:0]           y,
    output logic [2*WIDTH-1:0]           out_err
);

    localparam int D  = WIDTH / DIGIT_W;
    localparam int N  = D * D;
    localparam int KW = $clog2(N);
    localparam int TW = $clog2(2 * D);
    localparam int PW = 2 * WIDTH;

    state_t          state;
    logic [KW-1:0]   k;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [TW-1:0]   thr_lat;
    logic [PW-1:0]   acc;

    logic [KW-1:0]        i_idx;
    logic [KW-1:0]        j_idx;
    logic [KW:0]          pair_sum;
    logic [DIGIT_W-1:0]   a_digit;
    logic [DIGIT_W-1:0]   b_digit;
    logic                 use_approx;
    logic [2*DIGIT_W-1:0] prod;
    logic [PW-1:0]        acc_next;
    logic                 accept;
    logic                 last_pair;

    assign accept    = (state == IDLE) && in_valid && in_ready;
    assign last_pair = (k == KW'(N - 1));

    // Pair k covers digit i of a and digit j of b, with i varying fastest.
    // Because DIGIT_W is 4, shifting by {idx, 2'b00} selects digit idx.
    always_comb begin
        i_idx      = k % KW'(D);
        j_idx      = k / KW'(D);
        pair_sum   = {1'b0, i_idx} + {1'b0, j_idx};
        a_digit    = DIGIT_W'(a_lat >> {i_idx, 2'b00});
        b_digit    = DIGIT_W'(b_lat >> {j_idx, 2'b00});
        use_approx = (32'(pair_sum) >= 32'(thr_lat));
        acc_next   = acc + (PW'(prod) << {pair_sum, 2'b00});
    end

    rec_mult_core4x4 u_core (
        .a      (a_digit),
        .b      (b_digit),
        .approx (use_approx),
        .p      (prod)
    );

    // Operand latches are loaded only on accept. While the block is busy,
    // changes on the input ports have no effect.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_lat   <= a;
            b_lat   <= b;
            thr_lat <= approx_thr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            k         <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    k   <= k + 1'b1;
                    // y is loaded together with out_valid, so it is valid
                    // in the first DONE cycle.
                    if (last_pair) begin
                        y         <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef APPROX_ERR_STAT_EN
    logic [PW-1:0] err_q;
    logic [PW-1:0] exact_prod;

    assign exact_prod = PW'(a_lat) * PW'(b_lat);

    // Loaded on the same edge as y. Because approx <= exact, the difference
    // is never negative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (state == CALC && last_pair) begin
            err_q <= exact_prod - acc_next;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = '0;
`endif

endmodule

// File: tb/tb_iter_recursive_mult.sv
// Testbench for iter_recursive_mult. It drives a WIDTH=8 instance and a
// WIDTH=16 instance. Expected products come from a digit-level arithmetic
// model of the approximate multiplier.
module tb_iter_recursive_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv8, iv16, or8, or16;
    logic [15:0] a_in, b_in;
    logic [2:0]  thr_in;
    logic        ir8, ir16, ov8, ov16;
    logic [15:0] y8, e8;
    logic [31:0] y16, e16;

    int passes = 0;
    int checks = 0;

    longint qy0[$];
    longint qx0[$];
    longint qy1[$];
    longint qx1[$];

    always #5 clk = ~clk;

    iter_recursive_mult #(.WIDTH(8)) u8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (iv8),
        .in_ready   (ir8),
        .a          (a_in[7:0]),
        .b          (b_in[7:0]),
        .approx_thr (thr_in[1:0]),
        .out_valid  (ov8),
        .out_ready  (or8),
        .y          (y8),
        .out_err    (e8)
    );

    iter_recursive_mult #(.WIDTH(16)) u16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (iv16),
        .in_ready   (ir16),
        .a          (a_in),
        .b          (b_in),
        .approx_thr (thr_in),
        .out_valid  (ov16),
        .out_ready  (or16),
        .y          (y16),
        .out_err    (e16)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic longint am2(input longint x, input longint z);
        return (x == 3 && z == 3) ? 64'd7 : x * z;
    endfunction

    function automatic longint am4(input longint x, input longint z);
        return am2(x % 4, z % 4) + 4 * am2(x / 4, z % 4)
             + 4 * am2(x % 4, z / 4) + 16 * am2(x / 4, z / 4);
    endfunction

    function automatic longint model(input longint av, input longint bv, input int d, input int thr);
        longint acc = 0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                longint ad = (av >> (4 * i)) & 15;
                longint bd = (bv >> (4 * j)) & 15;
                longint p  = (i + j >= thr) ? am4(ad, bd) : ad * bd;
                acc += p << (4 * (i + j));
            end
        end
        return acc;
    endfunction

    function automatic longint exp_err(input longint exact, input longint yv);
`ifdef APPROX_ERR_STAT_EN
        return exact - yv;
`else
        return 0;
`endif
    endfunction

    function automatic longint rdy(input int s);
        return s != 0 ? longint'(ir16) : longint'(ir8);
    endfunction

    function automatic longint vld(input int s);
        return s != 0 ? longint'(ov16) : longint'(ov8);
    endfunction

    task automatic set_iv(input int s, input logic v);
        if (s != 0) iv16 = v; else iv8 = v;
    endtask

    task automatic set_or(input int s, input logic v);
        if (s != 0) or16 = v; else or8 = v;
    endtask

    // While out_valid is high, y and out_err must equal the model value of the
    // single operation in flight on every cycle, including held cycles.
    always @(negedge clk) begin
        if (rst_n && ov8) begin
            chk("mon8_inflight", qy0.size(), 1);
            if (qy0.size() > 0) begin
                chk("mon8_y", longint'(y8), qy0[0]);
                chk("mon8_err", longint'(e8), exp_err(qx0[0], qy0[0]));
            end
        end
        if (rst_n && ov16) begin
            chk("mon16_inflight", qy1.size(), 1);
            if (qy1.size() > 0) begin
                chk("mon16_y", longint'(y16), qy1[0]);
                chk("mon16_err", longint'(e16), exp_err(qx1[0], qy1[0]));
            end
        end
    end

    task automatic op(input int s, input longint av, input longint bv, input int thr,
                      input int hold, input bit poke, output longint ygot, output longint egot);
        int n;
        int d;
        int lat;
        int w;
        n = (s != 0) ? 16 : 4;
        d = (s != 0) ? 4 : 2;
        w = 0;
        while (rdy(s) == 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("wait_in_ready", rdy(s), 1);
        @(negedge clk);
        a_in   = 16'(av);
        b_in   = 16'(bv);
        thr_in = 3'(thr);
        set_iv(s, 1'b1);
        @(posedge clk);
        if (s != 0) begin
            qy1.push_back(model(av, bv, d, thr));
            qx1.push_back(av * bv);
        end else begin
            qy0.push_back(model(av, bv, d, thr));
            qx0.push_back(av * bv);
        end
        #1 chk("busy_in_ready", rdy(s), 0);
        @(negedge clk);
        set_iv(s, 1'b0);
        a_in   = 16'($urandom);
        b_in   = 16'($urandom);
        thr_in = 3'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (vld(s) == 0 && lat < 100);
        chk("latency", lat, n);
        ygot = (s != 0) ? longint'(y16) : longint'(y8);
        egot = (s != 0) ? longint'(e16) : longint'(e8);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (poke) set_iv(s, 1'b1);
            @(posedge clk);
            #1;
            chk("hold_out_valid", vld(s), 1);
            chk("hold_in_ready", rdy(s), 0);
        end
        @(negedge clk);
        set_iv(s, 1'b0);
        set_or(s, 1'b1);
        @(posedge clk);
        #1;
        set_or(s, 1'b0);
        if (s != 0) begin
            void'(qy1.pop_front());
            void'(qx1.pop_front());
        end else begin
            void'(qy0.pop_front());
            void'(qx0.pop_front());
        end
        chk("out_valid_drop", vld(s), 0);
        chk("in_ready_back", rdy(s), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        longint yg;
        longint eg;
        longint av;
        longint bv;
        int     thr;
        rst_n = 1'b0;
        iv8 = 1'b0; iv16 = 1'b0; or8 = 1'b0; or16 = 1'b0;
        a_in = '0; b_in = '0; thr_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready8", ir8, 1);
        chk("rst_out_valid8", ov8, 0);
        chk("rst_y8", y8, 0);
        chk("rst_err8", e8, 0);
        chk("rst_in_ready16", ir16, 1);
        chk("rst_out_valid16", ov16, 0);
        chk("rst_y16", y16, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fully exact at the maximum threshold.
        op(0, 255, 255, 3, 0, 0, yg, eg);
        chk("t1_y", yg, 65025);
        chk("t1_err", eg, 0);

        // Only the top digit pair is approximate.
        op(0, 'hF0, 'hF0, 2, 0, 0, yg, eg);
        chk("t2_y", yg, 44800);
`ifdef APPROX_ERR_STAT_EN
        chk("t2_err", eg, 12800);
`else
        chk("t2_err", eg, 0);
`endif

        op(0, 3, 3, 0, 0, 0, yg, eg);
        chk("t3_y_3x3", yg, 7);
        op(0, 2, 3, 0, 0, 0, yg, eg);
        chk("t3_y_2x3", yg, 6);
        op(0, 255, 255, 0, 0, 0, yg, eg);
        chk("pin_w8_ff_thr0", yg, 50575);

        // Back-pressure for 5 cycles while new in_valid requests arrive.
        op(0, 'hA7, 'h5C, 1, 5, 1, yg, eg);
        op(0, 'h3B, 'hE2, 2, 0, 0, yg, eg);
        chk("t4_next_op", yg, model('h3B, 'hE2, 2, 2));

        // Reset while the operation is in CALC with k=2.
        @(negedge clk);
        a_in = 16'h0055; b_in = 16'h0066; thr_in = 3'd3; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", ov8, 0);
        chk("t5_rst_y", y8, 0);
        chk("t5_rst_in_ready", ir8, 1);
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 12, 13, 3, 0, 0, yg, eg);
        chk("t5_y", yg, 156);

        // WIDTH=16, fully exact, random operands.
        for (int n = 0; n < 200; n++) begin
            av = longint'($urandom_range(0, 65535));
            bv = longint'($urandom_range(0, 65535));
            op(1, av, bv, 7, int'($urandom_range(0, 2)), 0, yg, eg);
            chk("t6_exact", yg, av * bv);
        end

        op(1, 'hFFFF, 'hFFFF, 0, 0, 0, yg, eg);
        chk("t6_ffff_thr0_model", yg, model('hFFFF, 'hFFFF, 4, 0));
        chk("pin_w16_ffff_thr0", yg, 64'd3340428175);

        // Random thresholds on both widths; the monitor checks y against the model.
        for (int n = 0; n < 30; n++) begin
            thr = int'($urandom_range(0, 7));
            av  = longint'($urandom_range(0, 65535));
            bv  = longint'($urandom_range(0, 65535));
            op(1, av, bv, thr, int'($urandom_range(0, 1)), 0, yg, eg);
            thr = int'($urandom_range(0, 3));
            av  = longint'($urandom_range(0, 255));
            bv  = longint'($urandom_range(0, 255));
            op(0, av, bv, thr, int'($urandom_range(0, 1)), 1, yg, eg);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
